bluetooth_cmd_scheduler: RTL and testbench

Multi-requester command scheduler in front of the `bluetooth_encoder` datapath. It arbitrates round-robin among `NUM_REQ` command sources and drives the encoder's `start` / `input_data` / `command_select` for the winning command. It then waits for `done` with a timeout, captures the 144-bit encoded packet and streams it out MSB-first as 18 bytes over a valid/ready byte interface. Only one command is in flight at any time, so the encoder is never restarted while busy.

---
 rtl/bluetooth_cmd_scheduler.sv | 152 +++++++++++++++
 tb/tb_bluetooth_cmd_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bluetooth_cmd_scheduler.sv
// bluetooth_cmd_scheduler
//   Round-robin command scheduler in front of the bluetooth_encoder datapath.
//   One command in flight at a time: grant -> start encoder -> wait for done
//   (with timeout) -> stream the 144-bit packet out MSB-first as 18 bytes.
// Ports:
//   clk, reset              clock, async active-high reset
//   req_valid/data/cmd      per-requester command sources (packed, req i at slice i)
//   req_ready               one-hot grant, only in IDLE
//   enc_start/input_data/command_select  encoder control
//   enc_done/output_data    encoder completion and packet
//   tx_byte/valid/ready/last/src         byte stream out
//   busy, err_timeout       status
module bluetooth_cmd_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]  req_cmd,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  enc_start,
  output logic [32:0]           enc_input_data,
  output logic [3:0]            enc_command_select,
  input  logic                  enc_done,
  input  logic [143:0]          enc_output_data,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic [SW-1:0]         tx_src,
  output logic                  busy,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cmd;
  } cmd_t;

  localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);
  localparam logic [4:0]    LAST_IDX = 5'd17;

  state_t state, nxt;

  logic [NUM_REQ-1:0][31:0] data_arr;
  logic [NUM_REQ-1:0][3:0]  cmd_arr;
  assign data_arr = req_data;
  assign cmd_arr  = req_cmd;

  logic [SW-1:0] last_grant, win_idx;
  logic          any_valid;
  cmd_t          cmd_q;
  logic [143:0]  sr;
  logic [TW-1:0] timer;
  logic [4:0]    idx;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    int j;
    win_idx   = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_grant) + k) % NUM_REQ;
      if (!any_valid && req_valid[j[SW-1:0]]) begin
        any_valid = 1'b1;
        win_idx   = j[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    req_ready = '0;
    enc_start = 1'b0;
    tx_valid  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (any_valid) begin
        req_ready[win_idx] = 1'b1;
        nxt                = S_ISSUE;
      end
      S_ISSUE: begin
        enc_start = 1'b1;
        nxt       = S_WAIT;
      end
      S_WAIT: begin
        // done beats the timer when both land in the same cycle
        if (enc_done)              nxt = S_SEND;
        else if (timer == TMR_MAX) nxt = S_IDLE;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && idx == LAST_IDX) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= SW'(NUM_REQ - 1);
      cmd_q       <= '0;
      tx_src      <= '0;
      sr          <= '0;
      timer       <= '0;
      idx         <= '0;
      err_timeout <= 1'b0;
    end else begin
      // registered so the pulse lands in the first IDLE cycle after the abort
      err_timeout <= (state == S_WAIT) && !enc_done && (timer == TMR_MAX);
      case (state)
        S_IDLE: if (any_valid) begin
          cmd_q      <= '{data: data_arr[win_idx], cmd: cmd_arr[win_idx]};
          tx_src     <= win_idx;
          last_grant <= win_idx;
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          if (enc_done) begin
            sr  <= enc_output_data;
            idx <= '0;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TW'(1);
          end
        end
        S_SEND: if (tx_ready) begin
          sr  <= {sr[135:0], 8'h00};
          idx <= idx + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign enc_input_data     = {1'b0, cmd_q.data};
  assign enc_command_select = cmd_q.cmd;
  assign tx_byte            = sr[143:136];
  assign tx_last            = tx_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_bluetooth_cmd_scheduler.sv
// Testbench for bluetooth_cmd_scheduler: table of single-command vectors,
// hand-written corner sequences, and a random phase, all checked by a
// transaction-level model (expected byte queue, grant order, event cycles).
module tb_bluetooth_cmd_scheduler;
  localparam int N  = 4;
  localparam int TO = 64;
  localparam logic [143:0] RAMP = 144'h0102030405060708090A0B0C0D0E0F101112;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N*4-1:0] req_cmd = '0;
  logic [N-1:0]   req_ready;
  logic           enc_start;
  logic [32:0]    enc_input_data;
  logic [3:0]     enc_command_select;
  logic           enc_done = 1'b0;
  logic [143:0]   enc_output_data = '0;
  logic [7:0]     tx_byte;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           tx_last;
  logic [1:0]     tx_src;
  logic           busy;
  logic           err_timeout;

  bluetooth_cmd_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_cmd(req_cmd), .req_ready(req_ready),
    .enc_start(enc_start), .enc_input_data(enc_input_data),
    .enc_command_select(enc_command_select),
    .enc_done(enc_done), .enc_output_data(enc_output_data),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .tx_src(tx_src), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  // ---------------- stimulus-side configuration ----------------
  bit ramp_mode = 1'b1;
  int rdly[N];          // encoder latency for each requester's command; -1 = never
  int txr_mode = 0;     // 0: ready high, 1: alternate, 2: random

  function automatic logic [143:0] pkt(input logic [31:0] d, input logic [3:0] c);
    if (ramp_mode) return RAMP;
    return {d, ~d, {d[15:0], d[31:16]}, d ^ 32'h9E3779B9, c, 4'hA, 8'h5C};
  endfunction

  // ---------------- encoder model ----------------
  int          cur_delay = 1;
  int          remain = 0;
  logic [31:0] e_d = '0;
  logic [3:0]  e_c = '0;

  always @(negedge clk) begin
    if (reset) begin
      remain   = 0;
      enc_done = 1'b0;
    end else if (enc_start) begin
      remain   = cur_delay;
      enc_done = 1'b0;
      e_d      = enc_input_data[31:0];
      e_c      = enc_command_select;
    end else if (remain > 0) begin
      remain--;
      enc_done = (remain == 0);
    end else begin
      enc_done = 1'b0;
    end
    enc_output_data = enc_done ? pkt(e_d, e_c)
                               : {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
  end

  // ---------------- transaction model / monitor ----------------
  typedef struct {
    logic [7:0] b;
    logic       l;
    logic [1:0] s;
  } exp_t;

  exp_t        exq[$];
  int          cyc = 0;
  bit          inflight = 1'b0;
  int          last_g = N - 1;
  int          g_cyc = -100;
  int          to_cyc = -100;
  logic [31:0] g_data = '0;
  logic [3:0]  g_cmd = '0;
  logic [N-1:0] hs_mask = '0;
  bit          pstall = 1'b0;
  logic [7:0]  pbyte;
  logic        plast;
  logic [1:0]  psrc;
  int          pkt_bytes = 0;
  int          stall_cnt = 0;
  int          to_count = 0;
  int          to_seen_cyc = -1;
  bit          to_flag = 1'b0;
  logic [32:0] ein_last = '0;
  int          glog[$];
  int          gcyc_log[$];

  always @(negedge clk) begin
    int           w;
    logic [N-1:0] exp_rdy;
    logic [143:0] p;
    exp_t         e;
    cyc++;
    if (reset) begin
      inflight = 1'b0;
      exq.delete();
      last_g   = N - 1;
      g_cyc    = -100;
      to_cyc   = -100;
      pstall   = 1'b0;
      hs_mask  = '0;
    end else begin
      if (cyc == to_cyc) inflight = 1'b0;
      w       = -1;
      exp_rdy = '0;
      if (!inflight)
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(last_g + k) % N]) w = (last_g + k) % N;
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (req_ready != '0 || exp_rdy != '0) chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, inflight);
      if (enc_start || cyc == g_cyc + 1) chk("enc_start", enc_start, cyc == g_cyc + 1);
      if (enc_start) begin
        chk("enc_input_data", enc_input_data, {1'b0, g_data});
        chk("enc_command_select", enc_command_select, g_cmd);
        ein_last = enc_input_data;
      end
      if (err_timeout || cyc == to_cyc) chk("err_timeout", err_timeout, cyc == to_cyc);
      if (err_timeout) begin
        to_count++;
        to_flag     = 1'b1;
        to_seen_cyc = cyc;
      end
      if (pstall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_byte", tx_byte, pbyte);
        chk("stall_last", tx_last, plast);
        chk("stall_src", tx_src, psrc);
      end
      pstall = tx_valid && !tx_ready;
      pbyte  = tx_byte;
      plast  = tx_last;
      psrc   = tx_src;
      if (pstall) stall_cnt++;
      if (tx_valid && tx_ready) begin
        if (exq.size() == 0) begin
          chk("tx_unexpected", tx_valid, 0);
        end else begin
          e = exq.pop_front();
          chk("tx_byte", tx_byte, e.b);
          chk("tx_last", tx_last, e.l);
          chk("tx_src", tx_src, e.s);
          pkt_bytes++;
          if (e.l) inflight = 1'b0;
        end
      end
      hs_mask = '0;
      if (w >= 0) begin
        hs_mask[w] = 1'b1;
        inflight   = 1'b1;
        last_g     = w;
        g_cyc      = cyc;
        g_data     = req_data[w*32 +: 32];
        g_cmd      = req_cmd[w*4 +: 4];
        cur_delay  = rdly[w];
        pkt_bytes  = 0;
        stall_cnt  = 0;
        to_flag    = 1'b0;
        ein_last   = '0;
        glog.push_back(w);
        gcyc_log.push_back(cyc);
        if (cur_delay >= 1 && cur_delay <= TO) begin
          p = pkt(g_data, g_cmd);
          for (int k = 0; k < 18; k++) begin
            e.b = p[143 - 8*k -: 8];
            e.l = (k == 17);
            e.s = w[1:0];
            exq.push_back(e);
          end
        end else begin
          // ISSUE at +1, TIMEOUT WAIT cycles, pulse in the following IDLE cycle
          to_cyc = cyc + TO + 2;
        end
      end
    end
  end

  // ---------------- tx_ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (txr_mode)
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = ($urandom_range(0, 9) < 7);
      default: tx_ready = 1'b1;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [3:0] c, input int dly);
    req_data[i*32 +: 32] = d;
    req_cmd[i*4 +: 4]    = c;
    rdly[i]              = dly;
    req_valid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int i, input string nm);
    int n = 0;
    do begin tick(); n++; end while (!hs_mask[i] && n < 300);
    if (!hs_mask[i]) fail_bound(nm);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin tick(); n++; end while (inflight && n < 400);
    if (inflight) fail_bound(nm);
  endtask

  function automatic int pick_delay();
    int r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(1, 6));
    if (r < 17) return int'($urandom_range(60, 64));
    if (r == 17) return 65;
    return -1;
  endfunction

  typedef struct {
    int          req;
    logic [31:0] data;
    logic [3:0]  cmd;
    int          dly;
    logic [32:0] exp_in;
    logic [1:0]  exp_src;
    int          exp_bytes;
    bit          exp_to;
  } vec_t;

  vec_t tbl[4];
  int   fexp[5] = '{0, 1, 2, 3, 0};

  initial begin
    int g1, tc0, gs, n;
    for (int i = 0; i < N; i++) rdly[i] = 1;

    tbl[0] = '{0, 32'h12345678, 4'h1, 3,  33'h012345678, 2'd0, 18, 1'b0};
    tbl[1] = '{2, 32'hFFFFFFFF, 4'hF, 1,  33'h0FFFFFFFF, 2'd2, 18, 1'b0};
    tbl[2] = '{3, 32'h00008001, 4'h6, TO, 33'h000008001, 2'd3, 18, 1'b0};
    tbl[3] = '{1, 32'hA5A55A5A, 4'h7, TO + 1, 33'h0A5A55A5A, 2'd1, 0, 1'b1};

    // reset values, sampled while reset is held
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_enc_start", enc_start, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_tx_src", tx_src, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_enc_in", enc_input_data, 0);
    chk("rst_enc_cmd", enc_command_select, 0);
    chk("rst_req_ready", req_ready, 0);
    do_reset();

    // table of single commands (ramp packet)
    ramp_mode = 1'b1;
    foreach (tbl[v]) begin
      set_req(tbl[v].req, tbl[v].data, tbl[v].cmd, tbl[v].dly);
      wait_grant(tbl[v].req, $sformatf("vec%0d_grant", v));
      req_valid[tbl[v].req] = 1'b0;
      wait_idle($sformatf("vec%0d_idle", v));
      chk($sformatf("vec%0d_enc_in", v), ein_last, tbl[v].exp_in);
      chk($sformatf("vec%0d_src", v), tx_src, tbl[v].exp_src);
      chk($sformatf("vec%0d_bytes", v), pkt_bytes, tbl[v].exp_bytes);
      chk($sformatf("vec%0d_timeout", v), to_flag, tbl[v].exp_to);
    end

    // fairness: all four hold valid, grants rotate 0,1,2,3,0
    ramp_mode = 1'b0;
    do_reset();
    gs = glog.size();
    for (int i = 0; i < N; i++) set_req(i, $urandom(), 4'(i + 1), 1);
    n = 0;
    while (glog.size() < gs + 5 && n < 300) begin tick(); n++; end
    if (glog.size() < gs + 5) fail_bound("fair_grants");
    else for (int k = 0; k < 5; k++) chk($sformatf("fair_grant%0d", k), glog[gs + k], fexp[k]);
    req_valid = '0;
    wait_idle("fair_idle");

    // backpressure: tx_ready alternates during SEND
    txr_mode = 1;
    set_req(2, 32'hCAFEF00D, 4'h9, 2);
    wait_grant(2, "bp_grant");
    req_valid[2] = 1'b0;
    wait_idle("bp_idle");
    chk("bp_bytes", pkt_bytes, 18);
    chk("bp_stalls_seen", stall_cnt >= 17, 1);
    txr_mode = 0;

    // timeout followed by an immediate grant in the pulse cycle
    set_req(1, 32'h0BADF00D, 4'h3, -1);
    wait_grant(1, "to_grant1");
    g1 = g_cyc;
    tc0 = to_count;
    req_valid[1] = 1'b0;
    set_req(2, 32'h13579BDF, 4'h5, 2);
    wait_grant(2, "to_grant2");
    req_valid[2] = 1'b0;
    chk("to_pulses", to_count - tc0, 1);
    chk("to_after_start", to_seen_cyc - (g1 + 1), TO + 1);
    chk("to_regrant_cycle", gcyc_log[gcyc_log.size() - 1], to_seen_cyc);
    wait_idle("to_idle");
    chk("to_next_bytes", pkt_bytes, 18);
    chk("to_next_src", tx_src, 2);

    // reset in the middle of SEND
    set_req(3, 32'h2468ACE0, 4'h2, 1);
    wait_grant(3, "rs_grant");
    req_valid[3] = 1'b0;
    n = 0;
    while (pkt_bytes < 5 && n < 100) begin tick(); n++; end
    if (pkt_bytes < 5) fail_bound("rs_bytes");
    set_req(0, 32'h11112222, 4'h4, 1);
    set_req(1, 32'h33334444, 4'h8, 1);
    reset = 1'b1;
    #1;
    chk("rs_tx_valid", tx_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_enc_start", enc_start, 0);
    chk("rs_err_timeout", err_timeout, 0);
    tick();
    reset = 1'b0;
    wait_grant(0, "rs_grant0");
    chk("rs_first_winner", glog[glog.size() - 1], 0);
    req_valid = '0;
    wait_idle("rs_idle");

    // random traffic against the model
    txr_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs_mask[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, $urandom(), 4'($urandom()), pick_delay());
      end
    end
    req_valid = '0;
    txr_mode  = 0;
    wait_idle("rand_idle");
    chk("rand_queue_empty", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
